// File: rtl/fpu_out_pkg.sv
// Shared types and constants for the FPU output / CPX request queue.
package fpu_out_pkg;

    localparam int unsigned CPX_REQ_W  = 8;
    localparam int unsigned THR_W      = 2;
    localparam int unsigned PIPE_W     = 3;
    localparam int unsigned FPU_DATA_W = 145;

    // One queued result: destination request, thread, winning pipe, packet.
    typedef struct packed {
        logic [CPX_REQ_W-1:0]  req;
        logic [THR_W-1:0]      thread;
        logic [PIPE_W-1:0]     pipe;
        logic [FPU_DATA_W-1:0] data;
    } fpu_out_entry_t;

    // Occupancy at which arbitration is told to stop; leaves room for the
    // two results already in flight through the arbitration pipeline.
    function automatic int unsigned stall_thresh(input int unsigned depth);
        return depth - 2;
    endfunction

endpackage

// File: rtl/fpu_out_cpx_q_if.sv
// Bus between the arbitration stage / CPX and the result request queue.
interface fpu_out_cpx_q_if #(
    parameter int unsigned DATA_W = 145
);
    logic [7:0]        fp_cpx_req_cq;
    logic [1:0]        req_thread;
    logic [2:0]        dest_rdy;
    logic [DATA_W-1:0] fp_out_data;
    logic [7:0]        cpx_fp_grant_cx;
    logic [7:0]        fpu_cpx_req_cq;
    logic [1:0]        fpu_cpx_thread;
    logic [DATA_W-1:0] fpu_cpx_data_ca;
    logic              fpu_cpx_data_vld_ca;
    logic              fpu_out_stall;
    logic              fpu_out_q_ovfl;

    // Environment side: arbitration stage plus CPX.
    modport master (
        output fp_cpx_req_cq, req_thread, dest_rdy, fp_out_data, cpx_fp_grant_cx,
        input  fpu_cpx_req_cq, fpu_cpx_thread, fpu_cpx_data_ca, fpu_cpx_data_vld_ca,
        input  fpu_out_stall, fpu_out_q_ovfl
    );

    // Queue side.
    modport slave (
        input  fp_cpx_req_cq, req_thread, dest_rdy, fp_out_data, cpx_fp_grant_cx,
        output fpu_cpx_req_cq, fpu_cpx_thread, fpu_cpx_data_ca, fpu_cpx_data_vld_ca,
        output fpu_out_stall, fpu_out_q_ovfl
    );
endinterface

// File: rtl/fpu_out_q_ram.sv
// Queue storage: DEPTH entries, one write port, async read at the head pointer.
module fpu_out_q_ram
    import fpu_out_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           i_wr_en,
    input  logic [AW-1:0]  i_wr_addr,
    input  fpu_out_entry_t i_wr_data,
    input  logic [AW-1:0]  i_rd_addr,
    output fpu_out_entry_t o_rd_data
);

    fpu_out_entry_t r_mem [DEPTH];

    // Write port; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fpu_out_cpx_q.sv
// FPU result request queue toward the CPX.
// Optional same-cycle bypass of an empty queue: define FPU_OUT_CPX_Q_BYPASS_EN.
module fpu_out_cpx_q
    import fpu_out_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = FPU_DATA_W
) (
    input  logic          rclk,
    input  logic          grst_l,
    fpu_out_cpx_q_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_ovfl;
    logic                 r_data_vld;
    logic [DATA_W-1:0]    r_data;

    fpu_out_entry_t       w_wr_entry;
    fpu_out_entry_t       w_rd_entry;
    fpu_out_entry_t       w_head;
    logic [CPX_REQ_W-1:0] w_req;
    logic [THR_W-1:0]     w_thread;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_wr_en;
    logic                 w_unused_pipe;

    assign w_wr_entry = '{req:    bus.fp_cpx_req_cq,
                          thread: bus.req_thread,
                          pipe:   bus.dest_rdy,
                          data:   FPU_DATA_W'(bus.fp_out_data)};

    assign w_empty = (r_count == CW'(0));
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = (bus.dest_rdy != '0);

    fpu_out_q_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk       (rclk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_entry)
    );

    // Head selection: queue head, or the incoming result when bypassing an empty queue.
    always_comb begin
        w_head   = w_rd_entry;
        w_req    = '0;
        w_thread = '0;
`ifdef FPU_OUT_CPX_Q_BYPASS_EN
        if (w_empty && w_push) begin
            w_head   = w_wr_entry;
            w_req    = w_wr_entry.req;
            w_thread = w_wr_entry.thread;
        end else if (!w_empty) begin
            w_req    = w_rd_entry.req;
            w_thread = w_rd_entry.thread;
        end
`else
        if (!w_empty) begin
            w_req    = w_rd_entry.req;
            w_thread = w_rd_entry.thread;
        end
`endif
    end

    // Pipe field is stored for debug visibility only; nothing downstream reads it.
    assign w_unused_pipe = ^w_head.pipe;

    assign w_pop   = ((bus.cpx_fp_grant_cx & w_req) != '0);
    assign w_wr_en = w_push && (!w_full || w_pop);

    // Pointers, occupancy, sticky overflow and the granted-data launch register.
    always_ff @(posedge rclk) begin
        if (!grst_l) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovfl     <= 1'b0;
            r_data_vld <= 1'b0;
            r_data     <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= r_count + CW'(w_wr_en) - CW'(w_pop);
            if (w_push && w_full && !w_pop) r_ovfl <= 1'b1;
            r_data_vld <= w_pop;
            r_data     <= w_pop ? DATA_W'(w_head.data) : '0;
        end
    end

    assign bus.fpu_cpx_req_cq      = w_req;
    assign bus.fpu_cpx_thread      = w_thread;
    assign bus.fpu_cpx_data_ca     = r_data;
    assign bus.fpu_cpx_data_vld_ca = r_data_vld;
    assign bus.fpu_out_stall       = (r_count >= CW'(stall_thresh(DEPTH)));
    assign bus.fpu_out_q_ovfl      = r_ovfl;

    // A pushed result with no destination can never be granted and wedges the queue.
    a_push_has_dest: assert property (@(posedge rclk) disable iff (!grst_l)
        w_push |-> (bus.fp_cpx_req_cq != '0));

endmodule

// File: tb/tb_fpu_out_cpx_q.sv
// Directed bench for fpu_out_cpx_q.
module tb_fpu_out_cpx_q;

    localparam int unsigned DW = 145;

    logic rclk;
    logic grst_l;
    int   errors;
    int   checks;

    fpu_out_cpx_q_if #(.DATA_W(DW)) bus();

    fpu_out_cpx_q #(.DEPTH(4), .DATA_W(DW)) dut (
        .rclk   (rclk),
        .grst_l (grst_l),
        .bus    (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [DW-1:0] pkt(input int k);
        logic [DW-1:0] p;
        p = '0;
        p[144:128] = 17'(k + 1);
        p[63:32]   = 32'(k * 7 + 3);
        p[31:0]    = 32'hC0DE_0000 + 32'(k);
        return p;
    endfunction

    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    task automatic set_push(input logic [7:0] req, input logic [1:0] thr, input logic [DW-1:0] d);
        bus.fp_cpx_req_cq = req;
        bus.req_thread    = thr;
        bus.dest_rdy      = 3'b001;
        bus.fp_out_data   = d;
    endtask

    task automatic clr_push;
        bus.fp_cpx_req_cq = '0;
        bus.req_thread    = '0;
        bus.dest_rdy      = '0;
        bus.fp_out_data   = '0;
    endtask

    task automatic test_reset;
        grst_l = 1'b0;
        clr_push();
        bus.cpx_fp_grant_cx = '0;
        tick(); tick();
        grst_l = 1'b1;
        tick();
        checks++; if (bus.fpu_cpx_req_cq !== 8'h00) begin errors++; $display("FAIL rst_req got %h exp 00", bus.fpu_cpx_req_cq); end
        checks++; if (bus.fpu_cpx_thread !== 2'd0) begin errors++; $display("FAIL rst_thread got %0d exp 0", bus.fpu_cpx_thread); end
        checks++; if (bus.fpu_cpx_data_vld_ca !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", bus.fpu_cpx_data_vld_ca); end
        checks++; if (bus.fpu_cpx_data_ca !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", bus.fpu_cpx_data_ca); end
        checks++; if (bus.fpu_out_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.fpu_out_stall); end
        checks++; if (bus.fpu_out_q_ovfl !== 1'b0) begin errors++; $display("FAIL rst_ovfl got %b exp 0", bus.fpu_out_q_ovfl); end
    endtask

    task automatic test_single;
        set_push(8'h04, 2'd2, pkt(1));
        tick();
        clr_push();
        checks++; if (bus.fpu_cpx_req_cq !== 8'h04) begin errors++; $display("FAIL single_req got %h exp 04", bus.fpu_cpx_req_cq); end
        checks++; if (bus.fpu_cpx_thread !== 2'd2) begin errors++; $display("FAIL single_thread got %0d exp 2", bus.fpu_cpx_thread); end
        bus.cpx_fp_grant_cx = 8'h04;
        tick();
        bus.cpx_fp_grant_cx = '0;
        checks++; if (bus.fpu_cpx_data_vld_ca !== 1'b1) begin errors++; $display("FAIL single_vld got %b exp 1", bus.fpu_cpx_data_vld_ca); end
        checks++; if (bus.fpu_cpx_data_ca !== pkt(1)) begin errors++; $display("FAIL single_data got %h exp %h", bus.fpu_cpx_data_ca, pkt(1)); end
        checks++; if (bus.fpu_cpx_req_cq !== 8'h00) begin errors++; $display("FAIL single_req_after got %h exp 00", bus.fpu_cpx_req_cq); end
        tick();
        checks++; if (bus.fpu_cpx_data_vld_ca !== 1'b0) begin errors++; $display("FAIL single_vld_drop got %b exp 0", bus.fpu_cpx_data_vld_ca); end
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < 4; i++) begin
            set_push(8'(1 << i), 2'(i), pkt(10 + i));
            tick();
            checks++;
            if (bus.fpu_out_stall !== ((i + 1) >= 2)) begin
                errors++; $display("FAIL fill_stall[%0d] got %b exp %b", i, bus.fpu_out_stall, ((i + 1) >= 2));
            end
        end
        clr_push();
        checks++; if (dut.r_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", dut.r_count); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.fpu_cpx_req_cq !== 8'(1 << i) || bus.fpu_cpx_thread !== 2'(i)) begin
                errors++; $display("FAIL drain_req[%0d] got %h/%0d exp %h/%0d", i, bus.fpu_cpx_req_cq, bus.fpu_cpx_thread, 8'(1 << i), i);
            end
            bus.cpx_fp_grant_cx = 8'(1 << i);
            tick();
            checks++;
            if (bus.fpu_cpx_data_vld_ca !== 1'b1 || bus.fpu_cpx_data_ca !== pkt(10 + i)) begin
                errors++; $display("FAIL drain_data[%0d] got %b/%h exp 1/%h", i, bus.fpu_cpx_data_vld_ca, bus.fpu_cpx_data_ca, pkt(10 + i));
            end
        end
        bus.cpx_fp_grant_cx = '0;
        checks++; if (bus.fpu_cpx_req_cq !== 8'h00) begin errors++; $display("FAIL drain_empty_req got %h exp 00", bus.fpu_cpx_req_cq); end
        checks++; if (bus.fpu_out_stall !== 1'b0) begin errors++; $display("FAIL drain_stall got %b exp 0", bus.fpu_out_stall); end
        tick();
    endtask

    task automatic test_full_push_pop;
        logic [7:0] exp_req [4];
        int         exp_pk  [4];
        for (int i = 0; i < 4; i++) begin
            set_push(8'(1 << i), 2'(i), pkt(20 + i));
            tick();
        end
        // Pop the head and push a new entry in the same cycle while full.
        bus.cpx_fp_grant_cx = 8'h01;
        set_push(8'h10, 2'd1, pkt(24));
        tick();
        bus.cpx_fp_grant_cx = '0;
        checks++; if (bus.fpu_cpx_data_ca !== pkt(20) || bus.fpu_cpx_data_vld_ca !== 1'b1) begin errors++; $display("FAIL full_pp_data got %b/%h exp 1/%h", bus.fpu_cpx_data_vld_ca, bus.fpu_cpx_data_ca, pkt(20)); end
        checks++; if (dut.r_count !== 3'd4) begin errors++; $display("FAIL full_pp_count got %0d exp 4", dut.r_count); end
        checks++; if (bus.fpu_out_q_ovfl !== 1'b0) begin errors++; $display("FAIL full_pp_ovfl got %b exp 0", bus.fpu_out_q_ovfl); end
        // Push while full with no pop: dropped.
        set_push(8'h20, 2'd3, pkt(25));
        tick();
        clr_push();
        checks++; if (bus.fpu_out_q_ovfl !== 1'b1) begin errors++; $display("FAIL ovfl_set got %b exp 1", bus.fpu_out_q_ovfl); end
        checks++; if (dut.r_count !== 3'd4) begin errors++; $display("FAIL ovfl_count got %0d exp 4", dut.r_count); end
        tick();
        checks++; if (bus.fpu_out_q_ovfl !== 1'b1) begin errors++; $display("FAIL ovfl_sticky got %b exp 1", bus.fpu_out_q_ovfl); end
        exp_req = '{8'h02, 8'h04, 8'h08, 8'h10};
        exp_pk  = '{21, 22, 23, 24};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.fpu_cpx_req_cq !== exp_req[i]) begin
                errors++; $display("FAIL full_drain_req[%0d] got %h exp %h", i, bus.fpu_cpx_req_cq, exp_req[i]);
            end
            bus.cpx_fp_grant_cx = exp_req[i];
            tick();
            checks++;
            if (bus.fpu_cpx_data_ca !== pkt(exp_pk[i])) begin
                errors++; $display("FAIL full_drain_data[%0d] got %h exp %h", i, bus.fpu_cpx_data_ca, pkt(exp_pk[i]));
            end
        end
        bus.cpx_fp_grant_cx = '0;
        checks++; if (bus.fpu_cpx_req_cq !== 8'h00) begin errors++; $display("FAIL full_drain_empty got %h exp 00", bus.fpu_cpx_req_cq); end
        checks++; if (bus.fpu_out_q_ovfl !== 1'b1) begin errors++; $display("FAIL ovfl_sticky2 got %b exp 1", bus.fpu_out_q_ovfl); end
    endtask

    task automatic test_grant_mismatch;
        set_push(8'h02, 2'd3, pkt(30));
        tick();
        clr_push();
        bus.cpx_fp_grant_cx = 8'h01;
        tick();
        checks++; if (bus.fpu_cpx_data_vld_ca !== 1'b0) begin errors++; $display("FAIL mis_vld got %b exp 0", bus.fpu_cpx_data_vld_ca); end
        checks++; if (bus.fpu_cpx_req_cq !== 8'h02 || bus.fpu_cpx_thread !== 2'd3) begin errors++; $display("FAIL mis_req got %h/%0d exp 02/3", bus.fpu_cpx_req_cq, bus.fpu_cpx_thread); end
        bus.cpx_fp_grant_cx = 8'h02;
        tick();
        bus.cpx_fp_grant_cx = '0;
        checks++; if (bus.fpu_cpx_data_vld_ca !== 1'b1 || bus.fpu_cpx_data_ca !== pkt(30)) begin errors++; $display("FAIL mis_pop got %b/%h exp 1/%h", bus.fpu_cpx_data_vld_ca, bus.fpu_cpx_data_ca, pkt(30)); end
        checks++; if (bus.fpu_cpx_req_cq !== 8'h00) begin errors++; $display("FAIL mis_empty got %h exp 00", bus.fpu_cpx_req_cq); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            set_push(8'(1 << i), 2'(i), pkt(40 + i));
            tick();
        end
        clr_push();
        bus.cpx_fp_grant_cx = 8'h01;
        grst_l = 1'b0;
        tick();
        bus.cpx_fp_grant_cx = '0;
        grst_l = 1'b1;
        checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", dut.r_count); end
        checks++; if (bus.fpu_cpx_req_cq !== 8'h00) begin errors++; $display("FAIL rmid_req got %h exp 00", bus.fpu_cpx_req_cq); end
        checks++; if (bus.fpu_cpx_data_vld_ca !== 1'b0) begin errors++; $display("FAIL rmid_vld got %b exp 0", bus.fpu_cpx_data_vld_ca); end
        checks++; if (bus.fpu_out_q_ovfl !== 1'b0) begin errors++; $display("FAIL rmid_ovfl got %b exp 0", bus.fpu_out_q_ovfl); end
        checks++; if (bus.fpu_out_stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got %b exp 0", bus.fpu_out_stall); end
        tick();
        checks++; if (bus.fpu_cpx_req_cq !== 8'h00 || bus.fpu_cpx_data_vld_ca !== 1'b0) begin errors++; $display("FAIL rmid_idle got %h/%b exp 00/0", bus.fpu_cpx_req_cq, bus.fpu_cpx_data_vld_ca); end
    endtask

`ifdef FPU_OUT_CPX_Q_BYPASS_EN
    task automatic test_bypass;
        set_push(8'h10, 2'd1, pkt(50));
        bus.cpx_fp_grant_cx = 8'h10;
        #1;
        checks++; if (bus.fpu_cpx_req_cq !== 8'h10 || bus.fpu_cpx_thread !== 2'd1) begin errors++; $display("FAIL byp_req got %h/%0d exp 10/1", bus.fpu_cpx_req_cq, bus.fpu_cpx_thread); end
        tick();
        clr_push();
        bus.cpx_fp_grant_cx = '0;
        checks++; if (bus.fpu_cpx_data_vld_ca !== 1'b1 || bus.fpu_cpx_data_ca !== pkt(50)) begin errors++; $display("FAIL byp_data got %b/%h exp 1/%h", bus.fpu_cpx_data_vld_ca, bus.fpu_cpx_data_ca, pkt(50)); end
        checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL byp_count got %0d exp 0", dut.r_count); end
        checks++; if (bus.fpu_cpx_req_cq !== 8'h00) begin errors++; $display("FAIL byp_empty got %h exp 00", bus.fpu_cpx_req_cq); end
    endtask
`else
    task automatic test_no_bypass;
        set_push(8'h10, 2'd1, pkt(50));
        bus.cpx_fp_grant_cx = 8'h10;
        #1;
        checks++; if (bus.fpu_cpx_req_cq !== 8'h00) begin errors++; $display("FAIL nobyp_req got %h exp 00", bus.fpu_cpx_req_cq); end
        tick();
        clr_push();
        checks++; if (bus.fpu_cpx_data_vld_ca !== 1'b0) begin errors++; $display("FAIL nobyp_vld got %b exp 0", bus.fpu_cpx_data_vld_ca); end
        checks++; if (dut.r_count !== 3'd1 || bus.fpu_cpx_req_cq !== 8'h10) begin errors++; $display("FAIL nobyp_queued got %0d/%h exp 1/10", dut.r_count, bus.fpu_cpx_req_cq); end
        tick();
        bus.cpx_fp_grant_cx = '0;
        checks++; if (bus.fpu_cpx_data_vld_ca !== 1'b1 || bus.fpu_cpx_data_ca !== pkt(50)) begin errors++; $display("FAIL nobyp_data got %b/%h exp 1/%h", bus.fpu_cpx_data_vld_ca, bus.fpu_cpx_data_ca, pkt(50)); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        grst_l = 1'b0;
        clr_push();
        bus.cpx_fp_grant_cx = '0;
        test_reset();
        test_single();
        test_fill_drain();
        test_full_push_pop();
        test_grant_mismatch();
        test_reset_mid();
`ifdef FPU_OUT_CPX_Q_BYPASS_EN
        test_bypass();
`else
        test_no_bypass();
`endif
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_out_cpx_q.md
# fpu_out_cpx_q

Result request queue between the FPU output arbitration stage and the CPX. Captures each arbitrated result (destination request vector, thread, winning pipe, result packet) in a small FIFO and presents the oldest entry to the CPX until it is granted. Drives a back-pressure stall to the arbitration stage so the two-cycle arbitration pipeline never overflows the queue.

## Interface
- DEPTH, 4: queue entries, power of two, minimum 4.
- DATA_W, 145: result packet width.
- rclk  in  1  global clock.
- grst_l  in  1  reset, synchronous, active-low.
- fp_cpx_req_cq  in  8  arbitrated destination request vector, one-hot or zero.
- req_thread  in  2  thread ID of the arbitrated result.
- dest_rdy  in  3  winning pipe {div,mul,add}; nonzero means push.
- fp_out_data  in  DATA_W  result packet, valid with dest_rdy.
- cpx_fp_grant_cx  in  8  CPX grant, per destination.
- fpu_cpx_req_cq  out  8  request to CPX for the queue head.
- fpu_cpx_thread  out  2  head thread ID, sideband to CPX request.
- fpu_cpx_data_ca  out  DATA_W  granted packet, cycle after grant.
- fpu_cpx_data_vld_ca  out  1  fpu_cpx_data_ca valid.
- fpu_out_stall  out  1  stop arbitrating new results.
- fpu_out_q_ovfl  out  1  sticky overflow error.

## Operation
- Push: dest_rdy != 0 writes {fp_cpx_req_cq, req_thread, dest_rdy, fp_out_data} at write pointer; count++.
- Head request: fpu_cpx_req_cq = head req vector when count != 0, else 0. fpu_cpx_thread = head thread, 0 when empty.
- Grant: (cpx_fp_grant_cx & fpu_cpx_req_cq) != 0 pops head; grant bits not matching the head request are ignored.
- Data: on grant, head packet registered into fpu_cpx_data_ca with fpu_cpx_data_vld_ca=1 next cycle; otherwise data register loads 0, vld 0.
- Pointers: DEPTH-bit wrap, log2(DEPTH) bits each; count is log2(DEPTH)+1 bits, 0..DEPTH.
- Simultaneous push and pop: both take effect, count unchanged; legal when full (pop frees slot for push).
- Push when count==DEPTH and no pop: entry dropped, pointers unchanged, fpu_out_q_ovfl set; sticky until reset.
- Push of req vector 0 with dest_rdy != 0: stored and forwarded unchanged; never granted, so it stalls the queue (protocol violation, flagged by assertion).
- Stall: fpu_out_stall = (count >= DEPTH-2), combinational from count register.

## Timing
- Reset (grst_l=0 at rclk edge): count, pointers, fpu_out_q_ovfl, fpu_cpx_data_vld_ca, fpu_cpx_data_ca cleared; hence fpu_cpx_req_cq=0, fpu_cpx_thread=0, fpu_out_stall=0. Storage contents not reset. Reset mid-operation discards all queued entries and any pending data launch.
- Push-to-request latency: 1 cycle (entry pushed at edge N requests in cycle N+1), without bypass.
- Grant-to-data latency: 1 cycle; head advances the same edge, next entry requests in the immediately following cycle (back-to-back grants give one packet per cycle).
- Stall-to-quiet: arbitration may deliver up to 2 pushes after stall asserts; the DEPTH-2 threshold absorbs them.

## Configuration
- FPU_OUT_CPX_Q_BYPASS_EN defined: when count==0 and dest_rdy != 0, fpu_cpx_req_cq/fpu_cpx_thread driven directly from the inputs in the same cycle; entry still written; if granted that cycle it is popped simultaneously (count stays 0) and data launches next cycle from the input packet.
- Undefined: no combinational input-to-output path; push-to-request latency always 1 cycle.

## Structure
- Package fpu_out_pkg: CPX_REQ_W=8, THR_W=2, PIPE_W=3, entry struct {req, thread, pipe, data}, stall threshold function of DEPTH.
- Sub-module fpu_out_q_ram: DEPTH x entry register file, one write port, one async read port at head pointer; no reset on storage.

## Test plan
- Reset then idle: all outputs 0; push req=8'h04 thr=2 -> fpu_cpx_req_cq=8'h04, thread=2 next cycle; grant 8'h04 -> data_vld=1 with pushed packet next cycle, req returns to 0.
- Push 4 entries (req 01,02,04,08) with no grant -> stall asserts at count 2, count=4; grant each in turn -> packets emerge in push order, one per cycle with continuous grants.
- Full queue, grant head and push simultaneously -> count stays 4, no overflow; push when full without grant -> entry dropped, fpu_out_q_ovfl=1 and stays set.
- Head req 8'h02, grant 8'h01 -> no pop, no data_vld; grant 8'h02 next cycle -> pop.
- Reset asserted with 3 entries queued and a grant pending -> next cycle count 0, req 0, data_vld 0, ovfl 0.
- With FPU_OUT_CPX_Q_BYPASS_EN, empty queue, push req 8'h10 with grant 8'h10 same cycle -> request visible same cycle, data_vld next cycle, count remains 0.
